// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//
// Boot-time system-identity checker. It acts as a small Avalon-MM read master
// in front of the system ID peripheral. After reset (when AUTO_START=1) or on a
// start pulse, it reads the ID word (address 0) and the timestamp word
// (address 1). It compares both words with build-time constants and then
// reports the result on sticky pass/fail flags. Downstream camera and control
// logic gate their enables on pass. A mismatched bitstream/software pairing
// therefore never starts streaming.
//
// Parameters
//   EXPECTED_ID     expected word at address 0
//   EXPECTED_TS     expected word at address 1
//   TIMEOUT_CYCLES  stall cycles one read may spend on waitrequest (1..65535)
//   MAX_RETRIES     full-sequence re-attempts after a timeout (0..15)
//   AUTO_START      1 = behave as if start were sampled in the first
//                   cycle after reset is released
//
// Ports
//   clock            single clock for all logic
//   reset            synchronous, active-high
//   start            one-cycle check request; dropped while busy
//   avm_read         Avalon read request
//   avm_address      word address, 0 = ID, 1 = timestamp
//   avm_waitrequest  fabric stall; data is valid when read=1 and wait=0
//   avm_readdata     32-bit read data
//   busy             a check is in progress
//   done             one-cycle pulse when a check completes (pass or fail)
//   pass             sticky: last check matched both words
//   fail             sticky: last check mismatched or timed out
//   timeout_err      sticky: last failure was caused by retry exhaustion
//   id_value         last captured ID word
//   ts_value         last captured timestamp word
// -----------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1365879267,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_read,
  output logic        avm_address,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // ---------------------------------------------------------------------------
  // State encoding. ST_RETRY is the single idle-bus cycle that is inserted
  // between a timed-out attempt and the restart at RD_ID.
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_ID  = 3'd1;
  localparam logic [2:0] ST_RD_TS  = 3'd2;
  localparam logic [2:0] ST_CMP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_RETRY  = 3'd5;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRIES);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q,   state_d;
  logic [15:0] tcnt_q,    tcnt_d;     // consecutive stalled cycles of this read
  logic [3:0]  retry_q,   retry_d;    // timeouts already absorbed by a restart
  logic        pass_q,    pass_d;
  logic        fail_q,    fail_d;
  logic        tmo_q,     tmo_d;
  logic [31:0] id_q,      id_d;
  logic [31:0] ts_q,      ts_d;
  logic        auto_q,    auto_d;     // pending auto-start after reset release

  // ---------------------------------------------------------------------------
  // Bus handshake decode
  // ---------------------------------------------------------------------------
  logic        reading;
  logic        accepted;
  logic        stalled;
  logic [15:0] tcnt_inc;
  logic        timed_out;
  logic        words_match;

  assign reading  = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign accepted = reading && !avm_waitrequest;
  assign stalled  = reading &&  avm_waitrequest;

  // The counter value including the current stall. A timeout fires on the
  // stall cycle that brings the count up to TIMEOUT_LIMIT. A read accepted in
  // that same cycle is not a stall, so acceptance wins over the timeout.
  assign tcnt_inc  = tcnt_q + 16'd1;
  assign timed_out = stalled && (tcnt_inc == TIMEOUT_LIMIT);

  assign words_match = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves a signal unassigned (which would infer a latch).
    state_d = state_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;
    auto_d  = 1'b0;   // the auto-start request lives for exactly one cycle

    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          state_d = ST_RD_ID;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
          retry_d = 4'd0;
          tcnt_d  = 16'd0;
        end
      end

      ST_RD_ID, ST_RD_TS: begin
        if (accepted) begin
          tcnt_d = 16'd0;
          if (state_q == ST_RD_ID) begin
            id_d    = avm_readdata;
            state_d = ST_RD_TS;
          end else begin
            ts_d    = avm_readdata;
            state_d = ST_CMP;
          end
        end else if (timed_out) begin
          tcnt_d = 16'd0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RETRY;
          end else begin
            // Captured words are left untouched, so software can still see
            // whatever the last successful reads returned.
            fail_d  = 1'b1;
            tmo_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      ST_RETRY: begin
        state_d = ST_RD_ID;
      end

      ST_CMP: begin
        pass_d  = words_match;
        fail_d  = !words_match;
        state_d = ST_FINISH;
      end

      ST_FINISH: begin
        // A start pulse arriving here is dropped, because busy is still high.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, and the ordering between
    // always blocks cannot change the result.
    if (reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= 16'd0;
      retry_q <= 4'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      auto_q  <= auto_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. These are pure decodes of the state register, so the read request
  // and address stay stable through a stall, and they drop in the cycle after
  // reset is sampled.
  // ---------------------------------------------------------------------------
  assign avm_read    = reading;
  assign avm_address = (state_q == ST_RD_TS);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FINISH);
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_checker
//
// Two checker instances share a clock. Each instance has its own reset and its
// own Avalon slave model.
//   dut_a: default parameters (auto-start on, long timeout).
//   dut_b: TIMEOUT_CYCLES=4, MAX_RETRIES=1, AUTO_START=0, custom expected words.
// Latency k counts negedges after the edge that samples start (or the first
// edge that samples reset=0). For example, done in cycle N+4 appears as k=4.
// -----------------------------------------------------------------------------
module tb_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1365879267;
  localparam logic [31:0] B_ID    = 32'hCAFE_0001;
  localparam logic [31:0] B_TS    = 32'h0000_0042;
  localparam int          STUCK   = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- dut_a ---
  logic        a_rst, a_start, a_read, a_addr, a_wait, a_busy, a_done;
  logic        a_pass, a_fail, a_tmo;
  logic [31:0] a_rdata, a_id, a_ts, a_id_word, a_ts_word;
  int          a_stall_id, a_stall_ts, a_scnt, a_lim;
  logic        a_prev_read, a_prev_addr;

  assign a_rdata = a_addr ? a_ts_word : a_id_word;

  sysid_checker dut_a (
    .clock(clk), .reset(a_rst), .start(a_start),
    .avm_read(a_read), .avm_address(a_addr), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail(a_fail), .timeout_err(a_tmo), .id_value(a_id), .ts_value(a_ts)
  );

  // Slave model A. It stalls each read a programmed number of cycles. Any read
  // that was stalled at the previous edge must still be held with the same
  // address.
  always @(negedge clk) begin
    if (a_prev_read && a_wait) begin
      check("a_read_hold", {31'd0, a_read}, 32'd1);
      check("a_addr_hold", {31'd0, a_addr}, {31'd0, a_prev_addr});
    end
    a_prev_read = a_read;
    a_prev_addr = a_addr;
    if (a_read) begin
      a_lim = a_addr ? a_stall_ts : a_stall_id;
      if (a_scnt < a_lim) begin a_wait = 1'b1; a_scnt++; end
      else begin a_wait = 1'b0; a_scnt = 0; end
    end else begin
      a_wait = 1'b0;
      a_scnt = 0;
    end
  end

  // ---------------------------------------------------------------- dut_b ---
  logic        b_rst, b_start, b_read, b_addr, b_wait, b_busy, b_done;
  logic        b_pass, b_fail, b_tmo;
  logic [31:0] b_rdata, b_id, b_ts, b_id_word, b_ts_word;
  int          b_stall_id, b_stall_ts, b_scnt, b_lim, b_reads;
  logic        b_prev_read;

  assign b_rdata = b_addr ? b_ts_word : b_id_word;

  sysid_checker #(
    .EXPECTED_ID(B_ID), .EXPECTED_TS(B_TS),
    .TIMEOUT_CYCLES(4), .MAX_RETRIES(1), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset(b_rst), .start(b_start),
    .avm_read(b_read), .avm_address(b_addr), .avm_waitrequest(b_wait),
    .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail(b_fail), .timeout_err(b_tmo), .id_value(b_id), .ts_value(b_ts)
  );

  // Slave model B. It also counts read bursts (each rising edge of avm_read).
  always @(negedge clk) begin
    if (b_read && !b_prev_read) b_reads++;
    b_prev_read = b_read;
    if (b_read) begin
      b_lim = b_addr ? b_stall_ts : b_stall_id;
      if (b_scnt < b_lim) begin b_wait = 1'b1; b_scnt++; end
      else begin b_wait = 1'b0; b_scnt = 0; end
    end else begin
      b_wait = 1'b0;
      b_scnt = 0;
    end
  end

  // ---------------------------------------------------------------- tasks ---
  task automatic wait_done_a(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (a_done === 1'b1) begin lat = k; break; end
    end
  endtask

  // With release_on_gap set, the stuck slave is freed in the first cycle of
  // the retry gap (busy but no read in flight).
  task automatic wait_done_b(input bit release_on_gap, output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (release_on_gap && b_busy && !b_read) b_stall_id = 0;
      if (b_done === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic check_after_done_a();
    @(negedge clk);
    check("a_done_width", {31'd0, a_done}, 32'd0);
    check("a_idle_busy",  {31'd0, a_busy}, 32'd0);
  endtask

  // ---------------------------------------------------------------- table ---
  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall_id;
    int          stall_ts;
    logic        exp_pass;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // -------------------------------------------------------------- watchdog --
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------------ main --
  initial begin
    int lat, dones, first_done, reads0, found;

    vecs[0] = '{32'd0,          32'd1365879268, 0,  0,  1'b0, 4};
    vecs[1] = '{32'd0,          TS_GOOD,        10, 10, 1'b1, 24};
    vecs[2] = '{32'd1,          TS_GOOD,        0,  0,  1'b0, 4};
    vecs[3] = '{32'd0,          32'd3513362915, 0,  0,  1'b0, 4};
    vecs[4] = '{32'd0,          TS_GOOD,        3,  0,  1'b1, 7};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  0,  5,  1'b0, 9};
    vecs[6] = '{32'd0,          TS_GOOD,        0,  0,  1'b1, 4};

    a_rst = 1'b1; a_start = 1'b0; a_wait = 1'b0; a_scnt = 0; a_lim = 0;
    a_prev_read = 1'b0; a_prev_addr = 1'b0;
    a_id_word = 32'd0; a_ts_word = TS_GOOD; a_stall_id = 0; a_stall_ts = 0;
    b_rst = 1'b1; b_start = 1'b0; b_wait = 1'b0; b_scnt = 0; b_lim = 0;
    b_prev_read = 1'b0; b_reads = 0;
    b_id_word = B_ID; b_ts_word = B_TS; b_stall_id = 0; b_stall_ts = 0;

    // ---- A: reset values, then auto-start pass ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_read", {31'd0, a_read}, 32'd0);
    check("a_rst_addr", {31'd0, a_addr}, 32'd0);
    check("a_rst_busy", {31'd0, a_busy}, 32'd0);
    check("a_rst_done", {31'd0, a_done}, 32'd0);
    check("a_rst_pass", {31'd0, a_pass}, 32'd0);
    check("a_rst_fail", {31'd0, a_fail}, 32'd0);
    check("a_rst_tmo",  {31'd0, a_tmo},  32'd0);
    check("a_rst_id",   a_id, 32'd0);
    check("a_rst_ts",   a_ts, 32'd0);
    a_rst = 1'b0;
    wait_done_a(lat);
    check("a_auto_lat",  lat, 32'd4);
    check("a_auto_pass", {31'd0, a_pass}, 32'd1);
    check("a_auto_fail", {31'd0, a_fail}, 32'd0);
    check("a_auto_id",   a_id, 32'd0);
    check("a_auto_ts",   a_ts, TS_GOOD);
    check_after_done_a();

    // ---- A: table-driven checks ----
    for (int i = 0; i < 7; i++) begin
      a_id_word  = vecs[i].id_word;
      a_ts_word  = vecs[i].ts_word;
      a_stall_id = vecs[i].stall_id;
      a_stall_ts = vecs[i].stall_ts;
      a_start    = 1'b1;
      wait_done_a(lat);
      check($sformatf("v%0d_lat", i),  lat, vecs[i].exp_lat);
      check($sformatf("v%0d_pass", i), {31'd0, a_pass}, {31'd0, vecs[i].exp_pass});
      check($sformatf("v%0d_fail", i), {31'd0, a_fail}, {31'd0, !vecs[i].exp_pass});
      check($sformatf("v%0d_tmo", i),  {31'd0, a_tmo},  32'd0);
      check($sformatf("v%0d_id", i),   a_id, vecs[i].id_word);
      check($sformatf("v%0d_ts", i),   a_ts, vecs[i].ts_word);
      check_after_done_a();
    end

    // ---- A: start during RD_ID and coincident with done ----
    a_stall_id = 0; a_stall_ts = 0;
    a_start = 1'b1;               // sampled at edge N (IDLE) and again at N+1 (RD_ID)
    dones = 0; first_done = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 2) a_start = a_done;   // re-pulse start in the done cycle
      if (a_done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
    end
    a_start = 1'b0;
    check("a_busy_start_dones", dones, 32'd1);
    check("a_busy_start_lat",   first_done, 32'd4);
    check("a_busy_start_idle",  {31'd0, a_busy}, 32'd0);
    check("a_busy_start_pass",  {31'd0, a_pass}, 32'd1);

    // ---- B: no auto-start ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_rst_read", {31'd0, b_read}, 32'd0);
    check("b_rst_busy", {31'd0, b_busy}, 32'd0);
    b_rst = 1'b0;
    repeat (6) @(negedge clk);
    check("b_noauto_reads", b_reads, 32'd0);
    check("b_noauto_busy",  {31'd0, b_busy}, 32'd0);

    // ---- B: plain pass against custom expected words ----
    b_start = 1'b1;
    wait_done_b(1'b0, lat);
    check("b_pass_lat",  lat, 32'd4);
    check("b_pass_pass", {31'd0, b_pass}, 32'd1);
    check("b_pass_id",   b_id, B_ID);
    check("b_pass_ts",   b_ts, B_TS);

    // ---- B: stuck waitrequest, one restart, then exhaustion ----
    // 4 stalled RD_ID cycles, 1 gap, 4 stalled RD_ID cycles, FINISH -> k=10.
    @(negedge clk);
    b_stall_id = STUCK;
    reads0 = b_reads;
    b_start = 1'b1;
    wait_done_b(1'b0, lat);
    check("b_stuck_lat",   lat, 32'd10);
    check("b_stuck_fail",  {31'd0, b_fail}, 32'd1);
    check("b_stuck_tmo",   {31'd0, b_tmo},  32'd1);
    check("b_stuck_pass",  {31'd0, b_pass}, 32'd0);
    check("b_stuck_reads", b_reads - reads0, 32'd2);
    check("b_stuck_id",    b_id, B_ID);
    check("b_stuck_ts",    b_ts, B_TS);

    // ---- B: stuck, released during the retry gap ----
    // 4 stalls, gap, ID, TS, CMP, FINISH -> k=9.
    @(negedge clk);
    b_stall_id = STUCK;
    b_start = 1'b1;
    wait_done_b(1'b1, lat);
    check("b_recover_lat",  lat, 32'd9);
    check("b_recover_pass", {31'd0, b_pass}, 32'd1);
    check("b_recover_fail", {31'd0, b_fail}, 32'd0);
    check("b_recover_tmo",  {31'd0, b_tmo},  32'd0);

    // ---- B: ID accepted on the 4th cycle (acceptance beats timeout), TS stuck ----
    // Per attempt: 4 ID cycles + 4 TS cycles + gap, twice, gap replaced by FINISH.
    @(negedge clk);
    b_stall_id = 3; b_stall_ts = STUCK;
    b_id_word = 32'h1111_2222;
    reads0 = b_reads;
    b_start = 1'b1;
    wait_done_b(1'b0, lat);
    check("b_worst_lat",   lat, 32'd18);
    check("b_worst_fail",  {31'd0, b_fail}, 32'd1);
    check("b_worst_tmo",   {31'd0, b_tmo},  32'd1);
    check("b_worst_reads", b_reads - reads0, 32'd2);
    check("b_worst_id",    b_id, 32'h1111_2222);
    check("b_worst_ts",    b_ts, B_TS);

    // ---- B: reset while in RD_TS ----
    @(negedge clk);
    b_stall_id = 0; b_stall_ts = STUCK;
    b_id_word = B_ID;
    b_start = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_read && b_addr) begin found = 1; break; end
    end
    check("b_reach_rd_ts", found, 32'd1);
    b_rst = 1'b1;
    @(negedge clk);
    check("b_mid_read", {31'd0, b_read}, 32'd0);
    check("b_mid_addr", {31'd0, b_addr}, 32'd0);
    check("b_mid_busy", {31'd0, b_busy}, 32'd0);
    check("b_mid_done", {31'd0, b_done}, 32'd0);
    check("b_mid_pass", {31'd0, b_pass}, 32'd0);
    check("b_mid_fail", {31'd0, b_fail}, 32'd0);
    check("b_mid_tmo",  {31'd0, b_tmo},  32'd0);
    check("b_mid_id",   b_id, 32'd0);
    check("b_mid_ts",   b_ts, 32'd0);
    b_rst = 1'b0;
    b_stall_ts = 0;
    reads0 = b_reads;
    repeat (6) @(negedge clk);
    check("b_post_rst_reads", b_reads - reads0, 32'd0);
    check("b_post_rst_busy",  {31'd0, b_busy}, 32'd0);
    b_start = 1'b1;
    wait_done_b(1'b0, lat);
    check("b_post_rst_lat",  lat, 32'd4);
    check("b_post_rst_pass", {31'd0, b_pass}, 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
